uart_pkt_parser: RTL and testbench
==================================

# uart_pkt_parser

Byte-level frame parser that sits directly downstream of the UART receiver. It consumes the receiver's byte plus one-cycle done strobe and assembles frames of the form SOF, CMD, LEN, payload[LEN], CHK. It verifies each frame's checksum, then stores the payload in a small buffer, presents CMD/LEN with a one-cycle valid pulse, and flags checksum, length and inter-byte timeout errors.

## Interface
Parameters:
- MAX_LEN, 16, maximum payload bytes; buffer depth.
- TIMEOUT_CLKS, 125_000, max idle clocks between bytes inside a frame (1 ms at 125 MHz).
- SOF, 8'hA5, start-of-frame byte.

Ports:
- iClk  in  1  clock.
- iRst  in  1  reset, synchronous, active-high.
- iRxByte  in  8  received byte; valid only while iRxDone=1.
- iRxDone  in  1  one-cycle byte strobe from the UART receiver.
- iRdAddr  in  $clog2(MAX_LEN)  payload buffer read address.
- oRdData  out  8  payload byte at iRdAddr (combinational read).
- oPktValid  out  1  one-cycle pulse: frame accepted.
- oCmd  out  8  CMD of last accepted frame.
- oLen  out  8  LEN of last accepted frame.
- oErr  out  1  one-cycle pulse: frame aborted.
- oErrCode  out  2  01 checksum, 10 length, 11 timeout; holds until next error.
- oBusy  out  1  high whenever the FSM is not in sIDLE.

## Operation
- FSM states: sIDLE, sCMD, sLEN, sPAYLOAD, sCHK. Transitions occur only on iRxDone, except on timeout.
- sIDLE: byte==SOF goes to sCMD. Any other byte is discarded silently with no error.
- sCMD: latch CMD into a working register. Go to sLEN. Checksum accumulator = CMD.
- sLEN:
  - LEN > MAX_LEN: oErr with code 10, go to sIDLE.
  - LEN==0: go to sCHK.
  - Otherwise go to sPAYLOAD.
  - In all cases, add LEN to the accumulator.
- sPAYLOAD: write the byte to buffer[idx], add it to the accumulator, idx++. After LEN bytes, go to sCHK.
- sCHK:
  - byte == accumulator (8-bit sum mod 256): pulse oPktValid, update oCmd/oLen.
  - Otherwise: pulse oErr with code 01.
  - Either way, go to sIDLE.
- Working CMD/LEN are separate from oCmd/oLen. oCmd/oLen change only on acceptance.
- Timeout: a counter runs in every state except sIDLE and clears on each iRxDone. When it reaches TIMEOUT_CLKS-1, pulse oErr with code 11 and go to sIDLE.
- Buffer contents are valid from oPktValid until the next SOF is accepted. The consumer must read before then; the buffer is not double-buffered. After a failed frame, payload bytes may be partially overwritten.
- A SOF byte received mid-frame is treated as data.

## Timing
- Reset values: oPktValid=0, oErr=0, oErrCode=00, oCmd=00, oLen=00, oBusy=0, FSM=sIDLE, counters=0.
- The buffer is not reset. oRdData is undefined until the first write.
- oPktValid and oErr are registered. Each asserts the cycle after the iRxDone that completes or aborts the frame.
- oCmd/oLen update in the same cycle as oPktValid.
- Timeout oErr asserts the cycle after the counter hits TIMEOUT_CLKS-1.
- iRxDone on consecutive cycles must be accepted with no byte loss.
- If iRxDone and the timeout terminal count coincide, the byte wins: it is processed and the counter clears.
- iRst mid-frame drops the frame with no oErr. The first frame after reset parses normally.
- oBusy is combinational from the state register.

## Structure
- Shared header uart_pkt_defs.vh holds: state encodings, error codes (ERR_CHK=2'b01, ERR_LEN=2'b10, ERR_TMO=2'b11), default SOF.
- One sub-module, uart_pkt_buf: MAX_LEN x 8 storage, synchronous write with enable, asynchronous read.
- The FSM, accumulator, index counter and timeout counter live in uart_pkt_parser.

## Test plan
Bench settings: MAX_LEN=16, TIMEOUT_CLKS=64. Bytes are driven as one-cycle iRxDone strobes.
- A5 01 02 10 20 33 -> oPktValid pulse, oCmd=01, oLen=02, buffer[0]=10, buffer[1]=20, oErr stays 0.
- A5 01 02 10 20 34 -> oErr pulse with oErrCode=01, no oPktValid, oCmd/oLen keep previous values.
- 00 FF A5 07 11 -> leading 00 FF ignored; oErr with code 10 the cycle after byte 11; oBusy=0 afterwards.
- A5 01, then 64 idle cycles -> oErr with code 11. Then A5 03 00 03 sent back-to-back on consecutive cycles -> oPktValid, oCmd=03, oLen=00.
- A5 01 02 10, then iRst pulse, then A5 09 01 AA B4 -> exactly one oPktValid with oCmd=09, oLen=01, buffer[0]=AA, and no oErr at any point.

Source files
------------

// File: rtl/uart_pkt_parser_pkg.sv
// Shared definitions for the UART packet parser: FSM state encoding,
// error codes, default start-of-frame byte and the checksum helper.
package uart_pkt_parser_pkg;

    typedef enum logic [2:0] {
        sIDLE    = 3'd0,
        sCMD     = 3'd1,
        sLEN     = 3'd2,
        sPAYLOAD = 3'd3,
        sCHK     = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CHK  = 2'b01;
    localparam logic [1:0] ERR_LEN  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam logic [7:0] DEFAULT_SOF = 8'hA5;

    // Frame checksum is a plain 8-bit running sum (mod 256).
    function automatic logic [7:0] chkAdd(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/uart_pkt_parser_if.sv
// Byte-in / packet-out bundle between the UART receiver side and the
// packet consumer. master = environment, slave = parser.
interface uart_pkt_parser_if #(
    parameter int MAX_LEN = 16
) ();
    localparam int AW = $clog2(MAX_LEN);

    logic [7:0]    iRxByte;
    logic          iRxDone;
    logic [AW-1:0] iRdAddr;
    logic [7:0]    oRdData;
    logic          oPktValid;
    logic [7:0]    oCmd;
    logic [7:0]    oLen;
    logic          oErr;
    logic [1:0]    oErrCode;
    logic          oBusy;

    modport master (
        output iRxByte, iRxDone, iRdAddr,
        input  oRdData, oPktValid, oCmd, oLen, oErr, oErrCode, oBusy
    );

    modport slave (
        input  iRxByte, iRxDone, iRdAddr,
        output oRdData, oPktValid, oCmd, oLen, oErr, oErrCode, oBusy
    );
endinterface

// File: rtl/uart_pkt_buf.sv
// Payload buffer: MAX_LEN x 8 storage, synchronous write, asynchronous read.
// Contents are intentionally not reset.
module uart_pkt_buf #(
    parameter int MAX_LEN = 16,
    parameter int AW      = $clog2(MAX_LEN)
) (
    input  logic          iClk,
    input  logic          iWe,
    input  logic [AW-1:0] iWrAddr,
    input  logic [7:0]    iWrData,
    input  logic [AW-1:0] iRdAddr,
    output logic [7:0]    oRdData
);
    logic [7:0] mem_r [MAX_LEN];

    // Store one payload byte per enabled clock.
    always_ff @(posedge iClk) begin
        if (iWe) begin
            mem_r[iWrAddr] <= iWrData;
        end
    end

    assign oRdData = mem_r[iRdAddr];
endmodule

// File: rtl/uart_pkt_parser.sv
// Frame parser downstream of the UART receiver: SOF, CMD, LEN, payload, CHK.
// Verifies the 8-bit additive checksum, stores the payload and reports
// accepted frames or checksum/length/timeout aborts as one-cycle pulses.
module uart_pkt_parser
    import uart_pkt_parser_pkg::*;
#(
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 125_000,
    parameter logic [7:0] SOF          = DEFAULT_SOF
) (
    input  logic             iClk,
    input  logic             iRst,
    uart_pkt_parser_if.slave bus
);
    localparam int            AW        = $clog2(MAX_LEN);
    localparam int            TW        = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    state_t        state_r;
    state_t        nextState_s;
    logic [7:0]    cmdWork_r;
    logic [7:0]    lenWork_r;
    logic [7:0]    acc_r;
    logic [7:0]    idx_r;
    logic [TW-1:0] tmoCnt_r;
    logic          tmoHit_s;
    logic          lastPayload_s;
    logic          accept_s;
    logic          abort_s;
    logic [1:0]    abortCode_s;
    logic          bufWe_s;
    logic          pktValid_r;
    logic          err_r;
    logic [1:0]    errCode_r;
    logic [7:0]    cmdOut_r;
    logic [7:0]    lenOut_r;

    // A byte arriving on the terminal count takes priority over the timeout.
    assign tmoHit_s      = (state_r != sIDLE) && !bus.iRxDone && (tmoCnt_r == TMO_LAST);
    assign lastPayload_s = ((idx_r + 8'd1) == lenWork_r);

    // FSM state register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_r <= sIDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // FSM next-state logic: advance only on a byte strobe, or abort on timeout.
    always_comb begin
        nextState_s = state_r;
        if (tmoHit_s) begin
            nextState_s = sIDLE;
        end else if (bus.iRxDone) begin
            case (state_r)
                sIDLE:    nextState_s = (bus.iRxByte == SOF) ? sCMD : sIDLE;
                sCMD:     nextState_s = sLEN;
                sLEN: begin
                    if (bus.iRxByte > MAX_LEN_B) begin
                        nextState_s = sIDLE;
                    end else if (bus.iRxByte == 8'd0) begin
                        nextState_s = sCHK;
                    end else begin
                        nextState_s = sPAYLOAD;
                    end
                end
                sPAYLOAD: nextState_s = lastPayload_s ? sCHK : sPAYLOAD;
                sCHK:     nextState_s = sIDLE;
                default:  nextState_s = sIDLE;
            endcase
        end else begin
            nextState_s = state_r;
        end
    end

    // FSM output logic: frame accept/abort events and buffer write enable.
    always_comb begin
        accept_s    = 1'b0;
        abort_s     = 1'b0;
        abortCode_s = ERR_NONE;
        bufWe_s     = 1'b0;
        if (tmoHit_s) begin
            abort_s     = 1'b1;
            abortCode_s = ERR_TMO;
        end else if (bus.iRxDone) begin
            case (state_r)
                sLEN: begin
                    if (bus.iRxByte > MAX_LEN_B) begin
                        abort_s     = 1'b1;
                        abortCode_s = ERR_LEN;
                    end else begin
                        abort_s = 1'b0;
                    end
                end
                sPAYLOAD: bufWe_s = 1'b1;
                sCHK: begin
                    if (bus.iRxByte == acc_r) begin
                        accept_s = 1'b1;
                    end else begin
                        abort_s     = 1'b1;
                        abortCode_s = ERR_CHK;
                    end
                end
                default: accept_s = 1'b0;
            endcase
        end else begin
            accept_s = 1'b0;
        end
    end

    // Working CMD/LEN, checksum accumulator and payload index.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            cmdWork_r <= 8'd0;
            lenWork_r <= 8'd0;
            acc_r     <= 8'd0;
            idx_r     <= 8'd0;
        end else if (bus.iRxDone) begin
            case (state_r)
                sCMD: begin
                    cmdWork_r <= bus.iRxByte;
                    acc_r     <= bus.iRxByte;
                end
                sLEN: begin
                    lenWork_r <= bus.iRxByte;
                    acc_r     <= chkAdd(acc_r, bus.iRxByte);
                    idx_r     <= 8'd0;
                end
                sPAYLOAD: begin
                    acc_r <= chkAdd(acc_r, bus.iRxByte);
                    idx_r <= idx_r + 8'd1;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    // Inter-byte idle counter: runs inside a frame, cleared by every byte.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            tmoCnt_r <= '0;
        end else if ((state_r == sIDLE) || bus.iRxDone || tmoHit_s) begin
            tmoCnt_r <= '0;
        end else begin
            tmoCnt_r <= tmoCnt_r + 1'b1;
        end
    end

    // Registered result outputs; CMD/LEN/code are held between events.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            pktValid_r <= 1'b0;
            err_r      <= 1'b0;
            errCode_r  <= ERR_NONE;
            cmdOut_r   <= 8'd0;
            lenOut_r   <= 8'd0;
        end else begin
            pktValid_r <= accept_s;
            err_r      <= abort_s;
            if (abort_s) begin
                errCode_r <= abortCode_s;
            end
            if (accept_s) begin
                cmdOut_r <= cmdWork_r;
                lenOut_r <= lenWork_r;
            end
        end
    end

    uart_pkt_buf #(
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) uBuf (
        .iClk    (iClk),
        .iWe     (bufWe_s),
        .iWrAddr (idx_r[AW-1:0]),
        .iWrData (bus.iRxByte),
        .iRdAddr (bus.iRdAddr),
        .oRdData (bus.oRdData)
    );

    assign bus.oPktValid = pktValid_r;
    assign bus.oErr      = err_r;
    assign bus.oErrCode  = errCode_r;
    assign bus.oCmd      = cmdOut_r;
    assign bus.oLen      = lenOut_r;
    assign bus.oBusy     = (state_r != sIDLE);
endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed self-checking bench for uart_pkt_parser (MAX_LEN=16, TIMEOUT_CLKS=64).
module tb_uart_pkt_parser;
    logic iClk = 1'b0;
    logic iRst = 1'b1;
    int   assertCount = 0;
    int   failCount   = 0;
    int   pktSeen     = 0;
    int   errSeen     = 0;

    uart_pkt_parser_if #(.MAX_LEN(16)) bus ();

    uart_pkt_parser #(
        .MAX_LEN      (16),
        .TIMEOUT_CLKS (64),
        .SOF          (8'hA5)
    ) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus)
    );

    // 100 MHz bench clock.
    always #5 iClk = ~iClk;

    // Count output pulses just after each active edge.
    always @(posedge iClk) begin
        #1;
        if (bus.oPktValid) pktSeen++;
        if (bus.oErr) errSeen++;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Present one byte strobe; returns on the next falling edge.
    task automatic driveByte(input logic [7:0] b);
        bus.iRxByte = b;
        bus.iRxDone = 1'b1;
        @(negedge iClk);
    endtask

    task automatic idleCycles(input int n);
        bus.iRxDone = 1'b0;
        repeat (n) @(negedge iClk);
    endtask

    task automatic test_reset;
        iRst = 1'b1;
        bus.iRxDone = 1'b0;
        bus.iRxByte = 8'h00;
        bus.iRdAddr = 4'd0;
        repeat (3) @(negedge iClk);
        iRst = 1'b0;
        @(negedge iClk);
        assertCount++;
        if (bus.oBusy !== 1'b0) begin failCount++; $display("FAIL reset_busy: got %b expected 0", bus.oBusy); end
        assertCount++;
        if (bus.oPktValid !== 1'b0) begin failCount++; $display("FAIL reset_valid: got %b expected 0", bus.oPktValid); end
        assertCount++;
        if (bus.oErr !== 1'b0) begin failCount++; $display("FAIL reset_err: got %b expected 0", bus.oErr); end
        assertCount++;
        if (bus.oErrCode !== 2'b00) begin failCount++; $display("FAIL reset_code: got %b expected 00", bus.oErrCode); end
        assertCount++;
        if ({bus.oCmd, bus.oLen} !== 16'h0000) begin failCount++; $display("FAIL reset_cmdlen: got %h expected 0000", {bus.oCmd, bus.oLen}); end
    endtask

    task automatic test_good_frame;
        int p0;
        int e0;
        p0 = pktSeen;
        e0 = errSeen;
        driveByte(8'hA5); idleCycles(1);
        driveByte(8'h01); idleCycles(1);
        driveByte(8'h02); idleCycles(2);
        driveByte(8'h10); driveByte(8'h20); idleCycles(1);
        driveByte(8'h33);
        assertCount++;
        if (bus.oPktValid !== 1'b1) begin failCount++; $display("FAIL good_valid: got %b expected 1", bus.oPktValid); end
        assertCount++;
        if ({bus.oCmd, bus.oLen} !== 16'h0102) begin failCount++; $display("FAIL good_cmdlen: got %h expected 0102", {bus.oCmd, bus.oLen}); end
        idleCycles(1);
        assertCount++;
        if (bus.oPktValid !== 1'b0) begin failCount++; $display("FAIL good_pulse_width: got %b expected 0", bus.oPktValid); end
        assertCount++;
        if (bus.oBusy !== 1'b0) begin failCount++; $display("FAIL good_busy_after: got %b expected 0", bus.oBusy); end
        bus.iRdAddr = 4'd0; #1;
        assertCount++;
        if (bus.oRdData !== 8'h10) begin failCount++; $display("FAIL good_buf0: got %h expected 10", bus.oRdData); end
        bus.iRdAddr = 4'd1; #1;
        assertCount++;
        if (bus.oRdData !== 8'h20) begin failCount++; $display("FAIL good_buf1: got %h expected 20", bus.oRdData); end
        assertCount++;
        if ((pktSeen - p0) !== 1 || (errSeen - e0) !== 0) begin failCount++; $display("FAIL good_pulse_count: got pkt=%0d err=%0d expected pkt=1 err=0", pktSeen - p0, errSeen - e0); end
        // SOF value inside a frame is ordinary data (CMD=A5, payload A5).
        driveByte(8'hA5); driveByte(8'hA5); driveByte(8'h01); driveByte(8'hA5); driveByte(8'h4B);
        assertCount++;
        if ({bus.oPktValid, bus.oCmd, bus.oLen} !== 17'h1_A501) begin failCount++; $display("FAIL sof_as_data: got %h expected 1a501", {bus.oPktValid, bus.oCmd, bus.oLen}); end
        idleCycles(1);
        bus.iRdAddr = 4'd0; #1;
        assertCount++;
        if (bus.oRdData !== 8'hA5) begin failCount++; $display("FAIL sof_as_data_buf0: got %h expected a5", bus.oRdData); end
    endtask

    task automatic test_bad_checksum;
        driveByte(8'hA5); driveByte(8'h01); driveByte(8'h02);
        driveByte(8'h10); driveByte(8'h20); driveByte(8'h34);
        assertCount++;
        if ({bus.oErr, bus.oErrCode, bus.oPktValid} !== 4'b1010) begin failCount++; $display("FAIL chk_err: got err/code/valid=%b expected 1010", {bus.oErr, bus.oErrCode, bus.oPktValid}); end
        assertCount++;
        if ({bus.oCmd, bus.oLen} !== 16'hA501) begin failCount++; $display("FAIL chk_hold_cmdlen: got %h expected a501", {bus.oCmd, bus.oLen}); end
        idleCycles(1);
        assertCount++;
        if ({bus.oErr, bus.oErrCode} !== 3'b001) begin failCount++; $display("FAIL chk_code_hold: got err/code=%b expected 001", {bus.oErr, bus.oErrCode}); end
    endtask

    task automatic test_bad_length;
        int e0;
        e0 = errSeen;
        driveByte(8'h00); idleCycles(1);
        driveByte(8'hFF); idleCycles(1);
        assertCount++;
        if ({bus.oBusy, bus.oErr} !== 2'b00) begin failCount++; $display("FAIL len_ignore_junk: got busy/err=%b expected 00", {bus.oBusy, bus.oErr}); end
        driveByte(8'hA5);
        assertCount++;
        if (bus.oBusy !== 1'b1) begin failCount++; $display("FAIL len_busy_after_sof: got %b expected 1", bus.oBusy); end
        idleCycles(1);
        driveByte(8'h07); idleCycles(1);
        driveByte(8'h11);
        assertCount++;
        if ({bus.oErr, bus.oErrCode} !== 3'b110) begin failCount++; $display("FAIL len_err: got err/code=%b expected 110", {bus.oErr, bus.oErrCode}); end
        idleCycles(1);
        assertCount++;
        if ({bus.oBusy, bus.oErr} !== 2'b00) begin failCount++; $display("FAIL len_idle_after: got busy/err=%b expected 00", {bus.oBusy, bus.oErr}); end
        assertCount++;
        if ((errSeen - e0) !== 1) begin failCount++; $display("FAIL len_err_count: got %0d expected 1", errSeen - e0); end
    endtask

    task automatic test_timeout_back_to_back;
        int firstErr;
        int e0;
        logic [1:0] code;
        firstErr = 0;
        code = 2'b00;
        driveByte(8'hA5); idleCycles(1);
        driveByte(8'h01);
        for (int i = 1; i <= 70 && firstErr == 0; i++) begin
            idleCycles(1);
            if (bus.oErr) begin
                firstErr = i;
                code = bus.oErrCode;
            end
        end
        assertCount++;
        if (firstErr !== 64) begin failCount++; $display("FAIL tmo_latency: got %0d cycles expected 64", firstErr); end
        assertCount++;
        if (code !== 2'b11) begin failCount++; $display("FAIL tmo_code: got %b expected 11", code); end
        assertCount++;
        if (bus.oBusy !== 1'b0) begin failCount++; $display("FAIL tmo_busy: got %b expected 0", bus.oBusy); end
        driveByte(8'hA5); driveByte(8'h03); driveByte(8'h00); driveByte(8'h03);
        assertCount++;
        if ({bus.oPktValid, bus.oCmd, bus.oLen} !== 17'h1_0300) begin failCount++; $display("FAIL b2b_zero_len: got %h expected 10300", {bus.oPktValid, bus.oCmd, bus.oLen}); end
        idleCycles(1);
        // Byte landing exactly on the terminal count must be taken.
        e0 = errSeen;
        driveByte(8'hA5); driveByte(8'h01);
        idleCycles(63);
        driveByte(8'h02);
        assertCount++;
        if ({bus.oErr, bus.oBusy} !== 2'b01) begin failCount++; $display("FAIL tmo_byte_wins: got err/busy=%b expected 01", {bus.oErr, bus.oBusy}); end
        driveByte(8'h10); driveByte(8'h20); driveByte(8'h33);
        assertCount++;
        if ({bus.oPktValid, bus.oCmd, bus.oLen} !== 17'h1_0102) begin failCount++; $display("FAIL tmo_byte_wins_frame: got %h expected 10102", {bus.oPktValid, bus.oCmd, bus.oLen}); end
        idleCycles(1);
        assertCount++;
        if ((errSeen - e0) !== 0) begin failCount++; $display("FAIL tmo_byte_wins_noerr: got %0d errors expected 0", errSeen - e0); end
    endtask

    task automatic test_reset_midframe;
        int p0;
        int e0;
        p0 = pktSeen;
        e0 = errSeen;
        driveByte(8'hA5); driveByte(8'h01); driveByte(8'h02); driveByte(8'h10);
        bus.iRxDone = 1'b0;
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        assertCount++;
        if ({bus.oBusy, bus.oCmd, bus.oLen} !== 17'h0_0000) begin failCount++; $display("FAIL rst_mid_state: got %h expected 00000", {bus.oBusy, bus.oCmd, bus.oLen}); end
        driveByte(8'hA5); driveByte(8'h09); driveByte(8'h01); driveByte(8'hAA); driveByte(8'hB4);
        assertCount++;
        if ({bus.oPktValid, bus.oCmd, bus.oLen} !== 17'h1_0901) begin failCount++; $display("FAIL rst_mid_frame: got %h expected 10901", {bus.oPktValid, bus.oCmd, bus.oLen}); end
        idleCycles(2);
        bus.iRdAddr = 4'd0; #1;
        assertCount++;
        if (bus.oRdData !== 8'hAA) begin failCount++; $display("FAIL rst_mid_buf0: got %h expected aa", bus.oRdData); end
        assertCount++;
        if ((pktSeen - p0) !== 1 || (errSeen - e0) !== 0) begin failCount++; $display("FAIL rst_mid_pulses: got pkt=%0d err=%0d expected pkt=1 err=0", pktSeen - p0, errSeen - e0); end
    endtask

    initial begin
        bus.iRxByte = 8'h00;
        bus.iRxDone = 1'b0;
        bus.iRdAddr = 4'd0;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_length();
        test_timeout_back_to_back();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
